// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for line_buffer: streams one IX x IY frame from a synchronous-read
// image memory into line_buffer and counts returned windows until done or drain timeout.
module line_buffer_ctrl #(
  parameter  int unsigned I_F_BW        = 8,
  parameter  int unsigned IX            = 28,
  parameter  int unsigned IY            = 28,
  parameter  int unsigned KX            = 5,
  parameter  int unsigned KY            = 5,
  parameter  int unsigned DRAIN_TIMEOUT = 64,
  localparam int unsigned NPIX          = IX * IY,
  localparam int unsigned NWIN          = (IX - KX + 1) * (IY - KY + 1),
  localparam int unsigned AW            = $clog2(NPIX),
  localparam int unsigned WW            = $clog2(NWIN + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_stall,
  output logic              o_mem_en,
  output logic [AW-1:0]     o_mem_addr,
  input  logic [I_F_BW-1:0] i_mem_data,
  output logic              o_in_valid,
  output logic [I_F_BW-1:0] o_in_pixel,
  input  logic              i_window_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [WW-1:0]     o_win_cnt
);

  localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [WW-1:0] win_q, win_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          busy_d, done_d, error_d;
  logic          mem_en_c;
  logic          win_inc_c;

  // Window pulses count only while a frame is in flight; the counter never passes NWIN.
  assign win_inc_c = o_busy && i_window_valid && (win_q != WW'(NWIN));

  // Next-state, counters and pulse generation.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    win_d    = win_q;
    tmo_d    = tmo_q;
    busy_d   = o_busy;
    done_d   = 1'b0;
    error_d  = 1'b0;
    mem_en_c = 1'b0;

    if (win_inc_c) begin
      win_d = win_q + WW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          win_d   = '0;
          tmo_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        if (!i_stall) begin
          mem_en_c = 1'b1;
          if (addr_q == AW'(NPIX - 1)) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        // The first DRAIN cycle carries the final pixel beat, so the timeout
        // count always starts at that beat.
        tmo_d = tmo_q + TW'(1);
        if (win_d == WW'(NWIN)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (tmo_q == TW'(DRAIN_TIMEOUT - 1)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      win_q      <= '0;
      tmo_q      <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
      o_in_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      win_q      <= win_d;
      tmo_q      <= tmo_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
      o_error    <= error_d;
      o_in_valid <= mem_en_c;
    end
  end

  // Read enable reacts to stall in the same cycle so no read is issued while paused.
  assign o_mem_en   = mem_en_c;
  assign o_mem_addr = addr_q;
  assign o_win_cnt  = win_q;
  assign o_in_pixel = o_in_valid ? i_mem_data : '0;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl: memory and line_buffer models, address/pixel
// scoreboard, table of frame scenarios, plus reset and back-to-back sequences.
module tb_line_buffer_ctrl;

  localparam int unsigned IX   = 28;
  localparam int unsigned IY   = 28;
  localparam int unsigned KX   = 5;
  localparam int unsigned KY   = 5;
  localparam int unsigned DT   = 64;
  localparam int unsigned NPIX = IX * IY;
  localparam int unsigned NWIN = (IX - KX + 1) * (IY - KY + 1);
  localparam int unsigned AW   = $clog2(NPIX);
  localparam int unsigned WW   = $clog2(NWIN + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_start;
  logic          i_stall;
  logic          o_mem_en;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    i_mem_data;
  logic          o_in_valid;
  logic [7:0]    o_in_pixel;
  logic          i_window_valid;
  logic          o_busy;
  logic          o_done;
  logic          o_error;
  logic [WW-1:0] o_win_cnt;

  always #5 clk = ~clk;

  line_buffer_ctrl #(
    .I_F_BW(8), .IX(IX), .IY(IY), .KX(KX), .KY(KY), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_start       (i_start),
    .i_stall       (i_stall),
    .o_mem_en      (o_mem_en),
    .o_mem_addr    (o_mem_addr),
    .i_mem_data    (i_mem_data),
    .o_in_valid    (o_in_valid),
    .o_in_pixel    (o_in_pixel),
    .i_window_valid(i_window_valid),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .o_win_cnt     (o_win_cnt)
  );

  typedef struct {
    int sa;          // first stall: address, length
    int sl;
    int sb;          // second stall: address, length
    int slb;
    int rs;          // cycle of a start pulse while busy (-1 none)
    int win_en;      // line_buffer model produces windows
    int exp_done;
    int exp_err;
    int exp_win;
    int exp_span;    // last beat cycle - first beat cycle
    int exp_end_lat; // done/error cycle - last beat cycle
    int tail;        // idle cycles observed after the frame ends
  } frame_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int exp_addr, beats, done_cnt, err_cnt;
  int start_cyc, first_en, first_valid, last_valid, done_cyc, err_cyc;
  logic [7:0] exp_q[$];
  int  win_en_g = 1;
  int  exp_win_g = 0;
  bit  win_pend = 1'b0;
  bit  force_win = 1'b0;
  bit  mem_req = 1'b0;
  int  mem_req_addr = 0;

  function automatic logic [7:0] pix(input int a);
    return 8'((a * 37) ^ (a >> 2) ^ 8'h5A);
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Memory read data and line_buffer window pulses, driven just after the edge.
  always @(posedge clk) begin
    #1;
    i_window_valid = win_pend | force_win;
    i_mem_data     = mem_req ? pix(mem_req_addr) : 8'(cyc * 13 + 1);
  end

  // Monitor and scoreboard: sample away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      win_pend = 1'b0;
      mem_req  = 1'b0;
      exp_q.delete();
      exp_addr = 0;
      beats    = 0;
    end else begin
      if (i_start && !o_busy) begin
        exp_q.delete();
        exp_addr = 0; beats = 0; done_cnt = 0; err_cnt = 0;
        first_en = -1; first_valid = -1; last_valid = -1; done_cyc = -1; err_cyc = -1;
        start_cyc = cyc;
      end
      mem_req      = o_mem_en;
      mem_req_addr = int'(o_mem_addr);
      if (o_mem_en) begin
        if (first_en < 0) first_en = cyc;
        check("mem_addr", o_mem_addr, exp_addr);
        check("stall_gate", i_stall, 0);
        exp_q.push_back(pix(exp_addr));
        exp_addr++;
      end
      win_pend = 1'b0;
      if (o_in_valid) begin
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
        check("beat_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("pixel", o_in_pixel, exp_q.pop_front());
        win_pend = (win_en_g != 0) && (beats % IX >= KX - 1) && (beats / IX >= KY - 1);
        beats++;
      end else begin
        check("pixel_gate", o_in_pixel, 0);
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy", o_busy, 0);
        check("done_wincnt", o_win_cnt, exp_win_g);
      end
      if (o_error) begin
        err_cnt++;
        err_cyc = cyc;
        check("error_busy", o_busy, 0);
      end
    end
  end

  // Called just after a rising edge; leaves just after a rising edge.
  task automatic run_frame(input frame_t f);
    int rem;
    bit a_done, b_done;
    win_en_g  = f.win_en;
    exp_win_g = f.exp_win;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("start_busy", o_busy, 1);
    check("start_wincnt", o_win_cnt, 0);
    rem = 0; a_done = 1'b0; b_done = 1'b0;
    for (int n = 1; n < 3000 && (done_cnt + err_cnt) == 0; n++) begin
      if (rem > 0) begin
        i_stall = 1'b1; rem--;
      end else if (!a_done && f.sa >= 0 && o_busy && int'(o_mem_addr) == f.sa) begin
        a_done = 1'b1; i_stall = 1'b1; rem = f.sl - 1;
      end else if (!b_done && f.sb >= 0 && o_busy && int'(o_mem_addr) == f.sb) begin
        b_done = 1'b1; i_stall = 1'b1; rem = f.slb - 1;
      end else begin
        i_stall = 1'b0;
      end
      i_start = (n == f.rs);
      @(posedge clk); #1;
    end
    i_stall = 1'b0;
    i_start = 1'b0;
    check("frame_end", done_cnt + err_cnt, 1);
    if (f.tail != 0) begin
      repeat (f.tail) begin @(posedge clk); #1; end
    end
    check("done_count", done_cnt, f.exp_done);
    check("error_count", err_cnt, f.exp_err);
    check("beats", beats, NPIX);
    check("addrs_issued", exp_addr, NPIX);
    check("final_wincnt", o_win_cnt, f.exp_win);
    check("final_busy", o_busy, 0);
    check("start_to_en", first_en - start_cyc, 1);
    check("en_to_valid", first_valid - first_en, 1);
    check("beat_span", last_valid - first_valid, f.exp_span);
    check("end_latency", (f.exp_done != 0) ? done_cyc - last_valid : err_cyc - last_valid,
          f.exp_end_lat);
  endtask

  frame_t frames[4];
  frame_t nom;
  frame_t nom_b2b;

  initial begin
    frames[0] = '{-1, 0, -1, 0, -1, 1, 1, 0, NWIN, NPIX - 1, 2, 70};
    frames[1] = '{100, 10, NPIX - 1, 1, -1, 1, 1, 0, NWIN, NPIX - 1 + 11, 2, 70};
    frames[2] = '{-1, 0, -1, 0, 300, 1, 1, 0, NWIN, NPIX - 1, 2, 70};
    frames[3] = '{-1, 0, -1, 0, -1, 0, 0, 1, 0, NPIX - 1, DT, 70};
    nom       = frames[0];
    nom_b2b   = frames[0];
    nom_b2b.tail = 0;

    reset_n = 1'b0; i_start = 1'b0; i_stall = 1'b0;
    i_window_valid = 1'b0; i_mem_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_en", o_mem_en, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    check("rst_in_valid", o_in_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_error", o_error, 0);
    check("rst_wincnt", o_win_cnt, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_frame(frames[i]);
    end

    // Reset in the middle of a frame, then a clean frame.
    win_en_g = 1; exp_win_g = NWIN;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int n = 0; n < 2000 && int'(o_mem_addr) != 400; n++) begin
      @(posedge clk); #1;
    end
    check("reach_addr_400", o_mem_addr, 400);
    reset_n = 1'b0;
    #1;
    check("mid_rst_mem_en", o_mem_en, 0);
    check("mid_rst_mem_addr", o_mem_addr, 0);
    check("mid_rst_in_valid", o_in_valid, 0);
    check("mid_rst_pixel", o_in_pixel, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_wincnt", o_win_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_done", o_done, 0);
    check("mid_rst_error", o_error, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_frame(nom);

    // Back-to-back frames, second start in the cycle after o_done.
    run_frame(nom_b2b);
    run_frame(nom);

    // Window pulses in IDLE must not disturb the held count.
    force_win = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    force_win = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("idle_wincnt_hold", o_win_cnt, NWIN);
    check("idle_busy", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Frame sequencer for line_buffer.
- On a start pulse it fetches one IX×IY frame from a synchronous-read image memory and streams it into line_buffer as a valid/pixel stream.
- Counts the windows line_buffer returns and signals done, or error on a drain timeout.
- Sits between the frame-store BRAM and line_buffer; gates the downstream conv stage via o_busy.

Parameters:
- I_F_BW, 8, pixel bit width
- IX, 28, frame width in pixels
- IY, 28, frame height in pixels
- KX, 5, window width
- KY, 5, window height
- DRAIN_TIMEOUT, 64, max cycles in DRAIN before error
- Derived: NPIX=IX*IY; NWIN=(IX-KX+1)*(IY-KY+1); AW=$clog2(NPIX); WW=$clog2(NWIN+1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start request
- i_stall  in  1  pause issuing new memory reads while high
- o_mem_en  out  1  memory read enable
- o_mem_addr  out  AW  memory read address
- i_mem_data  in  I_F_BW  memory read data, valid 1 cycle after o_mem_en
- o_in_valid  out  1  to line_buffer i_in_valid
- o_in_pixel  out  I_F_BW  to line_buffer i_in_pixel
- i_window_valid  in  1  from line_buffer o_window_valid
- o_busy  out  1  high from accepted start until done/error
- o_done  out  1  one-cycle pulse, frame complete
- o_error  out  1  one-cycle pulse, drain timeout
- o_win_cnt  out  WW  windows received in current frame

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; address, pixel and window counters 0; timeout counter 0.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - i_start=1 → FETCH next edge; o_busy=1; address, win_cnt and timeout cleared.
  - i_start is ignored in every other state.
- FETCH:
  - Each cycle with i_stall=0: o_mem_en=1, o_mem_addr=addr, addr++.
  - i_stall=1: o_mem_en=0, addr holds. A read issued the previous cycle still completes.
  - Address NPIX-1 issued → DRAIN next edge.
  - Addresses are issued strictly ascending 0..NPIX-1, each exactly once.
- Data path:
  - o_in_valid = o_mem_en delayed 1 cycle (registered).
  - o_in_pixel = i_mem_data passed combinationally, qualified by o_in_valid.
  - o_in_pixel must be 0 whenever o_in_valid=0.
  - Exactly NPIX valid beats per frame.
- Window counting:
  - Every cycle i_window_valid=1 while o_busy=1 increments o_win_cnt. This applies in FETCH and DRAIN.
  - i_window_valid is ignored in IDLE.
- DRAIN:
  - Timeout counter increments each cycle.
  - Counter is compared only after the final pixel beat (o_in_valid of NPIX-1) has been emitted.
  - o_win_cnt reaches NWIN (counting the current increment) → o_done pulses 1 cycle, o_busy=0, → IDLE.
  - Timeout counter reaches DRAIN_TIMEOUT without NWIN windows → o_error pulses 1 cycle, o_busy=0, → IDLE.
  - Simultaneous final window and timeout → done wins; no error.
- Window overflow: a window while o_win_cnt already equals NWIN cannot occur, because the FSM leaves on reaching NWIN. o_win_cnt saturates at NWIN.
- o_win_cnt holds its final value in IDLE until the next accepted start.
- Reset mid-frame: immediate return to IDLE, o_mem_en/o_in_valid drop at once, no done/error pulse.
- Frame sequencing: the start for frame N+1 is accepted earliest the cycle after o_done/o_error. Back-to-back frames are legal. Zero-cycle gap is not required.
- Latency: start → first o_mem_en = 1 cycle; o_mem_en → o_in_valid = 1 cycle.

Test Plan:
- Nominal frame (28×28, K=5, no stall, line_buffer model attached):
  - i_start at cycle 0 → o_mem_en high cycles 1..784 with addr 0..783.
  - o_in_valid cycles 2..785, pixels = mem[addr].
  - Exactly 576 window pulses counted; o_done one pulse; o_win_cnt=576; o_busy low after.
- Stall: i_stall high for 10 cycles at addr 100 and for 1 cycle at addr 783 →
  - No address skipped or duplicated.
  - o_in_valid gaps match the stall cycles.
  - 784 beats total; o_done still asserted, with 576 windows.
- Start while busy: second i_start at cycle 300 → ignored; single o_done; addresses not restarted.
- Drain timeout: i_window_valid tied 0 → o_error pulse DRAIN_TIMEOUT cycles after the last beat; no o_done; o_win_cnt=0; back to IDLE.
- Reset mid-frame: reset_n low at addr 400 →
  - All outputs 0 asynchronously.
  - Subsequent i_start restarts at addr 0 and completes normally.
- Back-to-back frames: i_start the cycle after o_done → second frame identical to the first; o_win_cnt restarts at 0 and ends at 576.
